// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that feeds one uart_tx serializer from NUM_REQ byte producers,
// with start-timeout detection and an optional inter-byte gap.
//
// state      | meaning
// IDLE       | scanning req, grants the round-robin winner
// START      | tx_en held, waiting for tx_busy to rise or the start timeout
// WAIT_DONE  | frame in flight, waiting for tx_busy to fall
// GAP        | enforced idle cycles before the next grant
module uart_tx_arb #(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 1024,
    parameter int GAP_CYCLES    = 0,
    parameter int CW            = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic                 tx_en,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic [2:0]           grant_id,
    output logic                 arb_busy,
    output logic                 err_timeout,
    input  logic                 clr_err
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_START     = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;
    localparam logic [1:0] ST_GAP       = 2'd3;

    localparam bit            HAS_GAP  = (GAP_CYCLES != 0);
    localparam logic [CW-1:0] TO_LAST  = CW'(START_TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [2:0]    LAST_RST = 3'(NUM_REQ - 1);
    localparam logic [1:0]    ST_AFTER = HAS_GAP ? ST_GAP : ST_IDLE;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               tx_en_q, tx_en_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [2:0]         grant_q, grant_d;
    logic [2:0]         last_q, last_d;
    logic               arb_busy_q, arb_busy_d;
    logic               err_q, err_d;

    logic [7:0] req_ext;
    logic [2:0] cand;
    logic       pick_valid;
    logic [2:0] pick_idx;
    logic [7:0] pick_byte;
    logic       err_set;

    assign req_ext = 8'(req);

    // Scan from farthest to nearest so the requester closest after last_q wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = 3'((int'(last_q) + k) % NUM_REQ);
            if (req_ext[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        pick_byte = 8'h00;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (3'(j) == pick_idx) begin
                pick_byte = req_data[8*j +: 8];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tx_en_d   = tx_en_q;
        tx_data_d = tx_data_q;
        ack_d     = '0;
        grant_d   = grant_q;
        last_d    = last_q;
        err_set   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_en_d = 1'b0;
                if (pick_valid) begin
                    ack_d     = NUM_REQ'(1) << pick_idx;
                    tx_data_d = pick_byte;
                    grant_d   = pick_idx;
                    last_d    = pick_idx;
                    tx_en_d   = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (tx_busy) begin
                    tx_en_d = 1'b0;
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == TO_LAST) begin
                    // Byte is dropped: the requester was already acked.
                    tx_en_d = 1'b0;
                    err_set = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_AFTER;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    cnt_d   = '0;
                    state_d = ST_AFTER;
                end
            end
            default: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase

        if (err_set) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end

        arb_busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            tx_en_q    <= 1'b0;
            tx_data_q  <= 8'h00;
            ack_q      <= '0;
            grant_q    <= 3'd0;
            last_q     <= LAST_RST;
            arb_busy_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_en_q    <= tx_en_d;
            tx_data_q  <= tx_data_d;
            ack_q      <= ack_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            arb_busy_q <= arb_busy_d;
            err_q      <= err_d;
        end
    end

    assign ack         = ack_q;
    assign tx_en       = tx_en_q;
    assign tx_data     = tx_data_q;
    assign grant_id    = grant_q;
    assign arb_busy    = arb_busy_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: directed scenarios plus random producers and a random serializer,
// every output compared each cycle against a transaction-level reference.
module tb_uart_tx_arb;

    localparam int NR  = 4;
    localparam int TO  = 8;
    localparam int GAP = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NR-1:0] req = '0;
    logic [8*NR-1:0] req_data = '0;
    logic          tx_busy = 1'b0;
    logic          clr_err = 1'b0;
    logic [NR-1:0] ack;
    logic          tx_en;
    logic [7:0]    tx_data;
    logic [2:0]    grant_id;
    logic          arb_busy;
    logic          err_timeout;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_on   = 1'b0;

    always #5 clk = ~clk;

    uart_tx_arb #(.NUM_REQ(NR), .START_TIMEOUT(TO), .GAP_CYCLES(GAP), .CW(16)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
        .tx_en(tx_en), .tx_data(tx_data), .tx_busy(tx_busy), .grant_id(grant_id),
        .arb_busy(arb_busy), .err_timeout(err_timeout), .clr_err(clr_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Serializer stand-in: busy rises ser_lat cycles into tx_en, stays ser_len cycles.
    int ser_lat = 2, ser_len = 5, ser_dly = 0, ser_left = 0;
    always @(negedge clk) begin
        if (ser_left > 0) begin
            ser_left--;
            if (ser_left == 0) tx_busy = 1'b0;
        end else if (tx_en && ser_lat > 0) begin
            ser_dly++;
            if (ser_dly >= ser_lat) begin
                tx_busy  = 1'b1;
                ser_left = ser_len;
                ser_dly  = 0;
            end
        end else begin
            ser_dly = 0;
        end
    end

    // Reference: arbitration by modular scan, timing by cycle budgets.
    localparam int P_IDLE = 0, P_START = 1, P_WAIT = 2, P_GAP = 3;
    int m_phase = P_IDLE, m_age = 0, m_gap_left = 0, m_last = NR-1, m_pick = 0;
    bit m_set_err = 1'b0;
    logic [NR-1:0] m_ack = '0;
    logic          m_en = 1'b0;
    logic [7:0]    m_data = '0;
    logic [2:0]    m_gid = '0;
    logic          m_err = 1'b0;

    function automatic int rr_pick(input logic [NR-1:0] r, input int last);
        for (int k = 1; k <= NR; k++) begin
            int idx;
            idx = (last + k) % NR;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_ack = '0; m_en = 1'b0; m_data = '0; m_gid = '0; m_err = 1'b0;
            m_last = NR-1; m_phase = P_IDLE; m_age = 0; m_gap_left = 0;
        end else begin
            m_ack = '0;
            m_set_err = 1'b0;
            case (m_phase)
                P_IDLE: begin
                    m_pick = rr_pick(req, m_last);
                    if (m_pick >= 0) begin
                        m_ack   = NR'(1) << m_pick;
                        m_data  = req_data[8*m_pick +: 8];
                        m_gid   = 3'(m_pick);
                        m_last  = m_pick;
                        m_en    = 1'b1;
                        m_age   = 0;
                        m_phase = P_START;
                    end
                end
                P_START: begin
                    m_age++;
                    if (tx_busy) begin
                        m_en = 1'b0;
                        m_phase = P_WAIT;
                    end else if (m_age == TO) begin
                        m_en = 1'b0;
                        m_set_err = 1'b1;
                        m_gap_left = GAP;
                        m_phase = (GAP > 0) ? P_GAP : P_IDLE;
                    end
                end
                P_WAIT: begin
                    if (!tx_busy) begin
                        m_gap_left = GAP;
                        m_phase = (GAP > 0) ? P_GAP : P_IDLE;
                    end
                end
                default: begin
                    m_gap_left--;
                    if (m_gap_left == 0) m_phase = P_IDLE;
                end
            endcase
            if (m_set_err) m_err = 1'b1;
            else if (clr_err) m_err = 1'b0;
        end
    end

    always begin
        tick();
        if (cmp_on) begin
            chk("ack", 32'(ack), 32'(m_ack));
            chk("tx_en", 32'(tx_en), 32'(m_en));
            chk("tx_data", 32'(tx_data), 32'(m_data));
            chk("grant_id", 32'(grant_id), 32'(m_gid));
            chk("arb_busy", 32'(arb_busy), 32'(m_phase != P_IDLE));
            chk("err_timeout", 32'(err_timeout), 32'(m_err));
        end
    end

    task automatic wait_ack(input string name, input int lim, output logic [NR-1:0] a);
        bit got;
        got = 1'b0;
        a = '0;
        for (int i = 0; i < lim && !got; i++) begin
            tick();
            if (ack != '0) begin
                a = ack;
                got = 1'b1;
            end
        end
        if (!got) bound_fail(name);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (arb_busy && n < 200) begin
            tick();
            n++;
        end
        if (arb_busy) bound_fail(name);
    endtask

    task automatic wait_frame(input string name);
        int n;
        n = 0;
        while (!(tx_busy && !tx_en) && n < 100) begin
            tick();
            n++;
        end
        if (!(tx_busy && !tx_en)) bound_fail(name);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [NR-1:0] a;
        int cnt, n, exp_id, bad;
        bit seen_hi;

        repeat (3) tick();
        cmp_on = 1'b1;
        chk("rst_tx_en", 32'(tx_en), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_grant", 32'(grant_id), 0);
        chk("rst_arb_busy", 32'(arb_busy), 0);
        chk("rst_err", 32'(err_timeout), 0);
        rst = 1'b0;
        tick();

        // Single request
        ser_lat = 4; ser_len = 20;
        req_data[23:16] = 8'hA5;
        req = 4'b0100;
        tick();
        chk("t1_ack", 32'(ack), 'h4);
        chk("t1_gid", 32'(grant_id), 2);
        chk("t1_data", 32'(tx_data), 'hA5);
        chk("t1_model_gid", 32'(m_gid), 2);
        req = '0;
        cnt = 0; n = 0;
        while (tx_en && n < 50) begin
            cnt++;
            tick();
            n++;
        end
        chk("t1_en_cycles", cnt, 4);
        wait_idle("t1_idle");
        chk("t1_arb_busy_low", 32'(arb_busy), 0);

        // Round-robin fairness from reset
        do_reset();
        ser_lat = 2; ser_len = 5;
        for (int i = 0; i < NR; i++) req_data[8*i +: 8] = 8'($urandom);
        req = 4'b1111;
        for (int g = 0; g < 8; g++) begin
            exp_id = g % NR;
            wait_ack("t2_wait", 200, a);
            chk("t2_ack", 32'(a), 32'(1) << exp_id);
            chk("t2_gid", 32'(grant_id), exp_id);
            chk("t2_data", 32'(tx_data), 32'(req_data[8*exp_id +: 8]));
            req_data[8*exp_id +: 8] = 8'($urandom);
            tick();
            chk("t2_ack_pulse", 32'(ack), 0);
        end
        req = '0;
        wait_idle("t2_idle");

        // Start timeout, clear, and set-beats-clear
        ser_lat = 0;
        req = 4'b0001;
        tick();
        chk("t3_ack", 32'(ack), 1);
        chk("t3_err_pre", 32'(err_timeout), 0);
        req = '0;
        cnt = 0; n = 0;
        while (tx_en && n < 50) begin
            cnt++;
            tick();
            n++;
        end
        chk("t3_en_cycles", cnt, 8);
        chk("t3_err", 32'(err_timeout), 1);
        chk("t3_model_err", 32'(m_err), 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("t3_clr", 32'(err_timeout), 0);
        wait_idle("t3_idle");
        req = 4'b0001;
        tick();
        req = '0;
        cnt = 1;
        while (cnt < 8) begin
            tick();
            cnt++;
        end
        chk("t3_en_last", 32'(tx_en), 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("t3_collide", 32'(err_timeout), 1);
        chk("t3_en_low", 32'(tx_en), 0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        wait_idle("t3_idle2");

        // Gap enforcement
        ser_lat = 2; ser_len = 6;
        req = 4'b1111;
        wait_ack("t4_first", 100, a);
        seen_hi = 1'b0; n = 0;
        while (n < 100) begin
            tick();
            n++;
            if (tx_busy) seen_hi = 1'b1;
            else if (seen_hi) break;
        end
        if (!seen_hi) bound_fail("t4_busy");
        cnt = 0;
        while (ack == '0 && cnt < 50) begin
            tick();
            cnt++;
        end
        chk("t4_spacing", cnt, 7);
        req = '0;
        wait_idle("t4_idle");

        // Reset mid-frame
        ser_lat = 2; ser_len = 10;
        req_data[23:16] = 8'h3C;
        req = 4'b0100;
        wait_ack("t5_first", 50, a);
        req = '0;
        wait_frame("t5_frame");
        rst = 1'b1;
        tick();
        chk("t5_tx_en", 32'(tx_en), 0);
        chk("t5_ack", 32'(ack), 0);
        chk("t5_arb_busy", 32'(arb_busy), 0);
        chk("t5_grant", 32'(grant_id), 0);
        req_data[15:8]  = 8'h11;
        req_data[31:24] = 8'h33;
        req = 4'b1010;
        rst = 1'b0;
        wait_ack("t5_after", 20, a);
        chk("t5_first_grant", 32'(a), 'h2);
        chk("t5_data", 32'(tx_data), 'h11);
        req = 4'b1000;
        wait_ack("t5_second", 200, a);
        chk("t5_second_grant", 32'(a), 'h8);
        req = '0;
        wait_idle("t5_idle");

        // Request raised and dropped while the arbiter is busy
        ser_lat = 2; ser_len = 10;
        req = 4'b0001;
        wait_ack("t6_first", 50, a);
        req = '0;
        wait_frame("t6_frame");
        bad = 0;
        req = 4'b1000;
        repeat (3) begin
            tick();
            if (ack != '0) bad++;
        end
        req = '0;
        n = 0;
        while (arb_busy && n < 100) begin
            tick();
            n++;
            if (ack != '0) bad++;
        end
        repeat (10) begin
            tick();
            if (ack != '0 || tx_en) bad++;
        end
        chk("t6_no_grant", bad, 0);

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            tick();
            for (int i = 0; i < NR; i++) begin
                if (ack[i]) req[i] = 1'b0;
                else if (!req[i]) begin
                    if ($urandom_range(7) == 0) begin
                        req_data[8*i +: 8] = 8'($urandom);
                        req[i] = 1'b1;
                    end
                end else if ($urandom_range(99) == 0) req[i] = 1'b0;
            end
            if (ack != '0) begin
                ser_lat = ($urandom_range(15) == 0) ? 0 : int'($urandom_range(5, 1));
                ser_len = int'($urandom_range(12, 1));
            end
            clr_err = ($urandom_range(15) == 0);
            rst = ($urandom_range(399) == 0);
        end
        rst = 1'b0;
        clr_err = 1'b0;
        req = '0;
        tick();
        wait_idle("rand_idle");
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
